// File: rtl/loteria_arbiter.sv
// Lottery terminal arbiter: round-robin grant of four ticket requesters onto
// a shared digit checker, sequencing clear/insert/finish and returning results.
module loteria_arbiter #(
    parameter int unsigned TIMEOUT = 64
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [3:0]  i_req,
    input  logic [79:0] i_ticket,
    output logic [3:0]  o_gnt,
    output logic        o_busy,
    output logic        o_chk_reset,
    output logic [3:0]  o_chk_num,
    output logic        o_chk_insert,
    output logic        o_chk_finish,
    input  logic        i_chk_done,
    input  logic [1:0]  i_chk_prize,
    input  logic        i_chk_win,
    output logic        o_rsp_valid,
    output logic [1:0]  o_rsp_id,
    output logic [1:0]  o_rsp_prize,
    output logic        o_rsp_win,
    output logic        o_rsp_timeout,
    output logic        o_rsp_invalid,
    output logic [7:0]  o_err_cnt
);

    localparam int unsigned CNT_W     = $clog2(TIMEOUT + 1);
    localparam int unsigned TICKET_W  = 20;
    localparam int unsigned DIGIT_W   = 4;
    localparam int unsigned LAST_DIG  = 4;

    typedef enum logic [2:0] {
        S_IDLE,
        S_GRANT,
        S_CLR,
        S_DIG,
        S_GAP,
        S_FIN,
        S_WAIT,
        S_RESP
    } state_t;

    state_t                r_state;
    logic [1:0]            r_ptr;
    logic [1:0]            r_id;
    logic [TICKET_W-1:0]   r_ticket;
    logic [2:0]            r_k;
    logic [CNT_W-1:0]      r_cnt;

    state_t                w_state_nxt;
    logic [1:0]            w_ptr_nxt;
    logic [1:0]            w_id_nxt;
    logic [TICKET_W-1:0]   w_ticket_nxt;
    logic [2:0]            w_k_nxt;
    logic [CNT_W-1:0]      w_cnt_nxt;

    logic [3:0]            w_gnt_nxt;
    logic                  w_chk_reset_nxt;
    logic [3:0]            w_chk_num_nxt;
    logic                  w_chk_insert_nxt;
    logic                  w_chk_finish_nxt;
    logic                  w_rsp_valid_nxt;
    logic [1:0]            w_rsp_id_nxt;
    logic [1:0]            w_rsp_prize_nxt;
    logic                  w_rsp_win_nxt;
    logic                  w_rsp_timeout_nxt;
    logic                  w_rsp_invalid_nxt;
    logic [7:0]            w_err_cnt_nxt;

    logic [1:0]            w_pick;
    logic [1:0]            w_idx;
    logic                  w_found;
    logic [TICKET_W-1:0]   w_pick_ticket;
    logic                  w_bad;
    logic [7:0]            w_err_inc;
    logic [CNT_W-1:0]      w_cnt_inc;

    // Digit k of a ticket, digit 0 being the most significant nibble
    function automatic logic [DIGIT_W-1:0] f_digit(input logic [TICKET_W-1:0] t,
                                                   input logic [2:0] k);
        logic [DIGIT_W-1:0] d;
        case (k)
            3'd0:    d = t[19:16];
            3'd1:    d = t[15:12];
            3'd2:    d = t[11:8];
            3'd3:    d = t[7:4];
            default: d = t[3:0];
        endcase
        return d;
    endfunction

    // Round-robin search starting one past the last served terminal
    always_comb begin
        w_pick  = '0;
        w_idx   = '0;
        w_found = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            w_idx = r_ptr + 2'(i);
            if (!w_found && i_req[w_idx]) begin
                w_found = 1'b1;
                w_pick  = w_idx;
            end
        end
    end

    // Ticket of the terminal chosen by the search
    always_comb begin
        case (w_pick)
            2'd0:    w_pick_ticket = i_ticket[19:0];
            2'd1:    w_pick_ticket = i_ticket[39:20];
            2'd2:    w_pick_ticket = i_ticket[59:40];
            default: w_pick_ticket = i_ticket[79:60];
        endcase
    end

    assign w_bad = (r_ticket[19:16] > 4'd9) | (r_ticket[15:12] > 4'd9) |
                   (r_ticket[11:8]  > 4'd9) | (r_ticket[7:4]   > 4'd9) |
                   (r_ticket[3:0]   > 4'd9);

    assign w_err_inc = (o_err_cnt == 8'hFF) ? o_err_cnt : o_err_cnt + 8'd1;
    assign w_cnt_inc = r_cnt + CNT_W'(1);

    // Next-state and next-output logic; outputs describe the state being entered
    always_comb begin
        w_state_nxt       = r_state;
        w_ptr_nxt         = r_ptr;
        w_id_nxt          = r_id;
        w_ticket_nxt      = r_ticket;
        w_k_nxt           = r_k;
        w_cnt_nxt         = r_cnt;
        w_gnt_nxt         = '0;
        w_chk_reset_nxt   = 1'b0;
        w_chk_num_nxt     = o_chk_num;
        w_chk_insert_nxt  = 1'b0;
        w_chk_finish_nxt  = 1'b0;
        w_rsp_valid_nxt   = 1'b0;
        w_rsp_id_nxt      = '0;
        w_rsp_prize_nxt   = '0;
        w_rsp_win_nxt     = 1'b0;
        w_rsp_timeout_nxt = 1'b0;
        w_rsp_invalid_nxt = 1'b0;
        w_err_cnt_nxt     = o_err_cnt;

        case (r_state)
            S_IDLE: begin
                if (|i_req) begin
                    w_id_nxt     = w_pick;
                    w_ticket_nxt = w_pick_ticket;
                    w_gnt_nxt    = 4'b0001 << w_pick;
                    w_state_nxt  = S_GRANT;
                end
            end
            S_GRANT: begin
                if (w_bad) begin
                    w_state_nxt       = S_RESP;
                    w_rsp_valid_nxt   = 1'b1;
                    w_rsp_id_nxt      = r_id;
                    w_rsp_invalid_nxt = 1'b1;
                    w_err_cnt_nxt     = w_err_inc;
                    w_ptr_nxt         = r_id;
                end else begin
                    w_state_nxt     = S_CLR;
                    w_chk_reset_nxt = 1'b1;
                end
            end
            S_CLR: begin
                w_k_nxt          = 3'd0;
                w_chk_insert_nxt = 1'b1;
                w_chk_num_nxt    = f_digit(r_ticket, 3'd0);
                w_state_nxt      = S_DIG;
            end
            S_DIG: begin
                w_state_nxt = S_GAP;
            end
            S_GAP: begin
                if (r_k == 3'(LAST_DIG)) begin
                    w_chk_finish_nxt = 1'b1;
                    w_cnt_nxt        = '0;
                    w_state_nxt      = S_FIN;
                end else begin
                    w_k_nxt          = r_k + 3'd1;
                    w_chk_insert_nxt = 1'b1;
                    w_chk_num_nxt    = f_digit(r_ticket, r_k + 3'd1);
                    w_state_nxt      = S_DIG;
                end
            end
            S_FIN: begin
                w_state_nxt = S_WAIT;
            end
            S_WAIT: begin
                if (i_chk_done) begin
                    w_state_nxt     = S_RESP;
                    w_rsp_valid_nxt = 1'b1;
                    w_rsp_id_nxt    = r_id;
                    w_rsp_prize_nxt = i_chk_prize;
                    w_rsp_win_nxt   = i_chk_win;
                    w_ptr_nxt       = r_id;
                end else if (w_cnt_inc == CNT_W'(TIMEOUT)) begin
                    w_state_nxt       = S_RESP;
                    w_rsp_valid_nxt   = 1'b1;
                    w_rsp_id_nxt      = r_id;
                    w_rsp_timeout_nxt = 1'b1;
                    w_err_cnt_nxt     = w_err_inc;
                    w_ptr_nxt         = r_id;
                end else begin
                    w_cnt_nxt = w_cnt_inc;
                end
            end
            S_RESP: begin
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // State, context and output registers with synchronous reset
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state       <= S_IDLE;
            r_ptr         <= 2'd3;
            r_id          <= '0;
            r_ticket      <= '0;
            r_k           <= '0;
            r_cnt         <= '0;
            o_gnt         <= '0;
            o_busy        <= 1'b0;
            o_chk_reset   <= 1'b0;
            o_chk_num     <= '0;
            o_chk_insert  <= 1'b0;
            o_chk_finish  <= 1'b0;
            o_rsp_valid   <= 1'b0;
            o_rsp_id      <= '0;
            o_rsp_prize   <= '0;
            o_rsp_win     <= 1'b0;
            o_rsp_timeout <= 1'b0;
            o_rsp_invalid <= 1'b0;
            o_err_cnt     <= '0;
        end else begin
            r_state       <= w_state_nxt;
            r_ptr         <= w_ptr_nxt;
            r_id          <= w_id_nxt;
            r_ticket      <= w_ticket_nxt;
            r_k           <= w_k_nxt;
            r_cnt         <= w_cnt_nxt;
            o_gnt         <= w_gnt_nxt;
            o_busy        <= (w_state_nxt != S_IDLE);
            o_chk_reset   <= w_chk_reset_nxt;
            o_chk_num     <= w_chk_num_nxt;
            o_chk_insert  <= w_chk_insert_nxt;
            o_chk_finish  <= w_chk_finish_nxt;
            o_rsp_valid   <= w_rsp_valid_nxt;
            o_rsp_id      <= w_rsp_id_nxt;
            o_rsp_prize   <= w_rsp_prize_nxt;
            o_rsp_win     <= w_rsp_win_nxt;
            o_rsp_timeout <= w_rsp_timeout_nxt;
            o_rsp_invalid <= w_rsp_invalid_nxt;
            o_err_cnt     <= w_err_cnt_nxt;
        end
    end

endmodule

// File: tb/tb_loteria_arbiter.sv
// Self-checking bench for loteria_arbiter: transaction-level reference model,
// every output compared every cycle as one packed vector.
module tb_loteria_arbiter;

    localparam int unsigned TO = 64;

    logic        clk = 1'b0;
    logic        reset;
    logic [3:0]  i_req;
    logic [79:0] i_ticket;
    logic [3:0]  o_gnt;
    logic        o_busy;
    logic        o_chk_reset;
    logic [3:0]  o_chk_num;
    logic        o_chk_insert;
    logic        o_chk_finish;
    logic        i_chk_done;
    logic [1:0]  i_chk_prize;
    logic        i_chk_win;
    logic        o_rsp_valid;
    logic [1:0]  o_rsp_id;
    logic [1:0]  o_rsp_prize;
    logic        o_rsp_win;
    logic        o_rsp_timeout;
    logic        o_rsp_invalid;
    logic [7:0]  o_err_cnt;

    loteria_arbiter #(.TIMEOUT(TO)) dut (
        .clk           (clk),
        .reset         (reset),
        .i_req         (i_req),
        .i_ticket      (i_ticket),
        .o_gnt         (o_gnt),
        .o_busy        (o_busy),
        .o_chk_reset   (o_chk_reset),
        .o_chk_num     (o_chk_num),
        .o_chk_insert  (o_chk_insert),
        .o_chk_finish  (o_chk_finish),
        .i_chk_done    (i_chk_done),
        .i_chk_prize   (i_chk_prize),
        .i_chk_win     (i_chk_win),
        .o_rsp_valid   (o_rsp_valid),
        .o_rsp_id      (o_rsp_id),
        .o_rsp_prize   (o_rsp_prize),
        .o_rsp_win     (o_rsp_win),
        .o_rsp_timeout (o_rsp_timeout),
        .o_rsp_invalid (o_rsp_invalid),
        .o_err_cnt     (o_err_cnt)
    );

    always #5 clk = ~clk;

    // Reference model state
    int         m_ptr;
    logic [3:0] m_num;
    int         m_err;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] pack(input logic b, input logic [3:0] g, input logic cr,
                                         input logic ci, input logic [3:0] cn, input logic cf,
                                         input logic rv, input logic [1:0] ri, input logic [1:0] rp,
                                         input logic rw, input logic rt, input logic rinv,
                                         input logic [7:0] ec);
        return {4'h0, b, g, cr, ci, cn, cf, rv, ri, rp, rw, rt, rinv, ec};
    endfunction

    function automatic logic [31:0] observed();
        return pack(o_busy, o_gnt, o_chk_reset, o_chk_insert, o_chk_num, o_chk_finish,
                    o_rsp_valid, o_rsp_id, o_rsp_prize, o_rsp_win, o_rsp_timeout,
                    o_rsp_invalid, o_err_cnt);
    endfunction

    function automatic int pick(input logic [3:0] r, input int p);
        for (int i = 1; i <= 4; i++)
            if (r[(p + i) % 4]) return (p + i) % 4;
        return -1;
    endfunction

    function automatic logic [3:0] digit(input logic [19:0] t, input int k);
        return t[19 - 4*k -: 4];
    endfunction

    function automatic logic [19:0] mk_ticket(input bit bad);
        logic [19:0] t;
        for (int k = 0; k < 5; k++) t[19 - 4*k -: 4] = 4'($urandom_range(0, 9));
        if (bad) t[19 - 4*$urandom_range(0, 4) -: 4] = 4'($urandom_range(10, 15));
        return t;
    endfunction

    function automatic logic [79:0] mk_tickets(input int bad_pct);
        logic [79:0] v;
        for (int i = 0; i < 4; i++) v[20*i +: 20] = mk_ticket($urandom_range(0, 99) < bad_pct);
        return v;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input string tag);
        reset = 1'b1;
        i_req = '0;
        i_chk_done = 1'b0;
        step();
        m_ptr = 3;
        m_num = '0;
        m_err = 0;
        check(tag, observed(), pack(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        reset = 1'b0;
    endtask

    task automatic idle_cycles(input int n);
        i_req = '0;
        for (int c = 0; c < n; c++) begin
            step();
            check("idle", observed(),
                  pack(0, 0, 0, 0, m_num, 0, 0, 0, 0, 0, 0, 0, 8'(m_err)));
        end
    endtask

    // One transaction from IDLE; mode 0 = checker answers after d cycles, 1 = never.
    // abort_at > 0 pulses reset after that offset and leaves the transaction unfinished.
    task automatic run_txn(input logic [3:0] req, input logic [79:0] tk, input int mode,
                           input int d, input logic [1:0] prize, input logic win,
                           input int abort_at, input string tag);
        int          id;
        int          e;
        bit          inv;
        logic [19:0] t20;
        logic [3:0]  g;
        logic        rv;
        i_req      = req;
        i_ticket   = tk;
        i_chk_done = 1'b0;
        id  = pick(req, m_ptr);
        t20 = tk[20*id +: 20];
        inv = 1'b0;
        for (int k = 0; k < 5; k++) if (digit(t20, k) > 4'd9) inv = 1'b1;
        e = inv ? 2 : ((mode == 1) ? 14 + int'(TO) : 15 + d);
        for (int o = 1; o <= e + 1; o++) begin
            step();
            g  = (o == 1) ? 4'(1 << id) : 4'h0;
            rv = (o == e);
            if (!inv && o >= 3 && o <= 11 && (o % 2) == 1) m_num = digit(t20, (o - 3) / 2);
            if (rv) begin
                if ((inv || mode == 1) && m_err < 255) m_err++;
                m_ptr = id;
            end
            check($sformatf("%s@%0d", tag, o), observed(),
                  pack(o <= e, g, !inv && o == 2,
                       !inv && o >= 3 && o <= 11 && (o % 2) == 1, m_num,
                       !inv && o == 13, rv,
                       rv ? 2'(id) : 2'd0,
                       (rv && !inv && mode == 0) ? prize : 2'd0,
                       rv && !inv && mode == 0 && win,
                       rv && !inv && mode == 1,
                       rv && inv, 8'(m_err)));
            if (o == abort_at) begin
                reset = 1'b1;
                step();
                m_ptr = 3;
                m_num = '0;
                m_err = 0;
                check({tag, "_abort"}, observed(), pack(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
                reset = 1'b0;
                i_chk_done = 1'b0;
                return;
            end
            if (o > 1 && o < e) begin
                i_ticket = {$urandom(), $urandom(), 16'($urandom())};
                i_req    = 4'($urandom());
            end
            if (!inv && mode == 0 && o == 14 + d) begin
                i_chk_done  = 1'b1;
                i_chk_prize = prize;
                i_chk_win   = win;
            end else begin
                i_chk_done  = (o <= 13) && ($urandom_range(0, 3) == 0);
                i_chk_prize = 2'($urandom());
                i_chk_win   = 1'($urandom());
            end
        end
        i_chk_done = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [79:0] tk;
        reset       = 1'b1;
        i_req       = '0;
        i_ticket    = '0;
        i_chk_done  = 1'b0;
        i_chk_prize = '0;
        i_chk_win   = 1'b0;
        m_ptr = 3;
        m_num = '0;
        m_err = 0;
        step();
        do_reset("reset_state");
        idle_cycles(2);

        // Directed: digits 5,0,9,6,7 with prize 01 and a win
        run_txn(4'b0001, 80'h50967, 0, 0, 2'b01, 1'b1, 0, "t_basic");

        // All four requesting: 0,1,2,3,0 after reset
        do_reset("reset_rr");
        for (int n = 0; n < 5; n++)
            run_txn(4'b1111, mk_tickets(0), 0, $urandom_range(0, 4),
                    2'($urandom()), 1'($urandom()), 0, "t_rr");

        // Checker never answers
        do_reset("reset_to");
        run_txn(4'b0100, mk_tickets(0), 1, 0, 2'b11, 1'b1, 0, "t_timeout");

        // Invalid digit in terminal 1
        do_reset("reset_inv");
        tk = mk_tickets(0);
        tk[39:20] = 20'h5A967;
        run_txn(4'b0010, tk, 0, 0, 2'b10, 1'b1, 0, "t_invalid");

        // Answer on the last permitted WAIT cycle
        run_txn(4'b0001, mk_tickets(0), 0, int'(TO) - 1, 2'b10, 1'b0, 0, "t_last_wait");

        // Lone requester re-granted back-to-back
        run_txn(4'b1000, mk_tickets(0), 0, 1, 2'b01, 1'b0, 0, "t_single_a");
        run_txn(4'b1000, mk_tickets(0), 0, 2, 2'b11, 1'b1, 0, "t_single_b");

        // Reset during DIG, then the held request is served from the start
        tk = mk_tickets(0);
        run_txn(4'b0100, tk, 0, 0, 2'b01, 1'b1, 5, "t_abort");
        run_txn(4'b0100, tk, 0, 0, 2'b01, 1'b1, 0, "t_reserve");

        // Random traffic
        for (int n = 0; n < 40; n++) begin
            if ($urandom_range(0, 3) == 0) idle_cycles($urandom_range(1, 3));
            run_txn(4'($urandom_range(1, 15)), mk_tickets(20),
                    ($urandom_range(0, 9) == 0) ? 1 : 0, $urandom_range(0, 12),
                    2'($urandom()), 1'($urandom()), 0, "t_rand");
        end

        // Error counter saturation
        for (int n = 0; n < 300; n++)
            run_txn(4'($urandom_range(1, 15)), mk_tickets(100), 0, 0, 2'b00, 1'b0, 0, "t_sat");
        idle_cycles(2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
